// File: rtl/scr1_dmem_sram_bridge_pkg.sv
// rtl/scr1_dmem_sram_bridge_pkg.sv - shared memory-interface encodings and bridge state codes
package scr1_dmem_sram_bridge_pkg;

    localparam logic       SCR1_MEM_CMD_RD         = 1'b0;
    localparam logic       SCR1_MEM_CMD_WR         = 1'b1;

    localparam logic [1:0] SCR1_MEM_WIDTH_BYTE     = 2'b00;
    localparam logic [1:0] SCR1_MEM_WIDTH_HWORD    = 2'b01;
    localparam logic [1:0] SCR1_MEM_WIDTH_WORD     = 2'b10;

    localparam logic [1:0] SCR1_MEM_RESP_NOTRDY    = 2'b00;
    localparam logic [1:0] SCR1_MEM_RESP_RDY_OK    = 2'b01;
    localparam logic [1:0] SCR1_MEM_RESP_RDY_ER    = 2'b10;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD       = 3'd1;
    localparam logic [2:0] ST_RD_WAIT  = 3'd2;
    localparam logic [2:0] ST_RMW_RD   = 3'd3;
    localparam logic [2:0] ST_RMW_WAIT = 3'd4;
    localparam logic [2:0] ST_RMW_WR   = 3'd5;
    localparam logic [2:0] ST_WR       = 3'd6;

    // Illegal width or an access not aligned to its own size.
    function automatic logic width_addr_bad(input logic [1:0] width, input logic [1:0] lsb);
        case (width)
            SCR1_MEM_WIDTH_BYTE:  width_addr_bad = 1'b0;
            SCR1_MEM_WIDTH_HWORD: width_addr_bad = lsb[0];
            SCR1_MEM_WIDTH_WORD:  width_addr_bad = |lsb;
            default:              width_addr_bad = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/scr1_dmem_sram_bridge_if.sv
// rtl/scr1_dmem_sram_bridge_if.sv - SCR1 pipe data-memory request/response bundle
interface scr1_dmem_sram_bridge_if;

    logic        dmem_req_i;
    logic        dmem_cmd_i;
    logic [1:0]  dmem_width_i;
    logic [31:0] dmem_addr_i;
    logic [31:0] dmem_wdata_i;
    logic        dmem_req_ack_o;
    logic [31:0] dmem_rdata_o;
    logic [1:0]  dmem_resp_o;

    modport master (
        output dmem_req_i, dmem_cmd_i, dmem_width_i, dmem_addr_i, dmem_wdata_i,
        input  dmem_req_ack_o, dmem_rdata_o, dmem_resp_o
    );

    modport slave (
        input  dmem_req_i, dmem_cmd_i, dmem_width_i, dmem_addr_i, dmem_wdata_i,
        output dmem_req_ack_o, dmem_rdata_o, dmem_resp_o
    );

endinterface

// File: rtl/scr1_dmem_lane_merge.sv
// rtl/scr1_dmem_lane_merge.sv - merges right-aligned store data into an old word for byte-maskless memories
module scr1_dmem_lane_merge
    import scr1_dmem_sram_bridge_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  width_i,
    input  logic [1:0]  offset_i,
    output logic [31:0] merged_word_o
);

    always_comb begin
        merged_word_o = old_word_i;
        case (width_i)
            SCR1_MEM_WIDTH_BYTE:  merged_word_o[{offset_i, 3'b000} +: 8]     = wdata_i[7:0];
            SCR1_MEM_WIDTH_HWORD: merged_word_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            SCR1_MEM_WIDTH_WORD:  merged_word_o = wdata_i;
            default:              merged_word_o = old_word_i;
        endcase
    end

endmodule

// File: rtl/scr1_dmem_sram_bridge.sv
// rtl/scr1_dmem_sram_bridge.sv - SCR1 dmem port to single-port SRAM bridge with read-modify-write for sub-word stores
module scr1_dmem_sram_bridge
    import scr1_dmem_sram_bridge_pkg::*;
#(
    parameter int          SRAM_AW   = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
)(
    input  logic                 clk,
    input  logic                 rst,
    scr1_dmem_sram_bridge_if.slave dmem,
    output logic                 sram_csb0_o,
    output logic                 sram_web0_o,
    output logic [SRAM_AW-1:0]   sram_addr0_o,
    output logic [31:0]          sram_din0_o,
    input  logic [31:0]          sram_dout0_i
);

    logic [2:0]         state_q,    state_d;
    logic [1:0]         width_q,    width_d;
    logic [SRAM_AW+1:0] addr_q,     addr_d;
    logic [31:0]        wdata_q,    wdata_d;
    logic [31:0]        old_word_q, old_word_d;
    logic [1:0]         resp_q,     resp_d;
    logic [31:0]        rdata_q,    rdata_d;

    logic        req_err;
    logic [31:0] merged_word;

    assign req_err = (dmem.dmem_addr_i[31:SRAM_AW+2] != BASE_ADDR[31:SRAM_AW+2])
                   || width_addr_bad(dmem.dmem_width_i, dmem.dmem_addr_i[1:0]);

    scr1_dmem_lane_merge u_lane_merge (
        .old_word_i    (old_word_q),
        .wdata_i       (wdata_q),
        .width_i       (width_q),
        .offset_i      (addr_q[1:0]),
        .merged_word_o (merged_word)
    );

    always_comb begin
        state_d    = state_q;
        width_d    = width_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        old_word_d = old_word_q;
        resp_d     = SCR1_MEM_RESP_NOTRDY;
        rdata_d    = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (dmem.dmem_req_i) begin
                    // Rejected requests never leave IDLE and never touch the SRAM bus.
                    if (req_err) begin
                        resp_d = SCR1_MEM_RESP_RDY_ER;
                    end else begin
                        width_d = dmem.dmem_width_i;
                        addr_d  = dmem.dmem_addr_i[SRAM_AW+1:0];
                        wdata_d = dmem.dmem_wdata_i;
                        if (dmem.dmem_cmd_i == SCR1_MEM_CMD_RD)
                            state_d = ST_RD;
                        else if (dmem.dmem_width_i == SCR1_MEM_WIDTH_WORD)
                            state_d = ST_WR;
                        else
                            state_d = ST_RMW_RD;
                    end
                end
            end
            ST_RD:       state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                rdata_d = sram_dout0_i;
                resp_d  = SCR1_MEM_RESP_RDY_OK;
                state_d = ST_IDLE;
            end
            ST_RMW_RD:   state_d = ST_RMW_WAIT;
            ST_RMW_WAIT: begin
                old_word_d = sram_dout0_i;
                state_d    = ST_RMW_WR;
            end
            ST_RMW_WR, ST_WR: begin
                resp_d  = SCR1_MEM_RESP_RDY_OK;
                state_d = ST_IDLE;
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            width_q    <= SCR1_MEM_WIDTH_BYTE;
            addr_q     <= '0;
            wdata_q    <= '0;
            old_word_q <= '0;
            resp_q     <= SCR1_MEM_RESP_NOTRDY;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            width_q    <= width_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            old_word_q <= old_word_d;
            resp_q     <= resp_d;
            rdata_q    <= rdata_d;
        end
    end

    // SRAM strobes decode straight from state, so an async reset drops any pending write at once.
    always_comb begin
        sram_csb0_o = 1'b1;
        sram_web0_o = 1'b1;
        case (state_q)
            ST_RD, ST_RMW_RD: sram_csb0_o = 1'b0;
            ST_WR, ST_RMW_WR: begin
                sram_csb0_o = 1'b0;
                sram_web0_o = 1'b0;
            end
            default: ;
        endcase
    end

    assign sram_addr0_o = addr_q[SRAM_AW+1:2];
    assign sram_din0_o  = (state_q == ST_RMW_WR) ? merged_word : wdata_q;

    assign dmem.dmem_req_ack_o = (state_q == ST_IDLE);
    assign dmem.dmem_resp_o    = resp_q;
    assign dmem.dmem_rdata_o   = rdata_q;

endmodule
